multiword_add_sequencer: RTL

//  Sequencer for wide add/subtract on one shared N-bit carry_select_adder.

---
 rtl/multiword_add_sequencer_if.sv | 29 ++
 rtl/multiword_add_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer_if.sv
// Request/response bundle between the datapath control FSM and the wide add/sub sequencer.
interface multiword_add_sequencer_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start_valid;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output start_valid, op_sub, a, b, res_ready,
        input  start_ready, res_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  start_valid, op_sub, a, b, res_ready,
        output start_ready, res_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract done one N-bit word per cycle on a single shared carry-select adder.
module carry_select_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    generate
        if (N < 2) begin : g_ripple
            logic [N:0] s;
            assign s    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            assign sum  = s[N-1:0];
            assign cout = s[N];
        end else begin : g_select
            localparam int L = N / 2;
            localparam int H = N - L;
            logic [L:0] lo;
            logic [H:0] hi0, hi1;
            // Upper half is precomputed for both carry-ins; the low-half carry picks one.
            assign lo   = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]} + {{L{1'b0}}, cin};
            assign hi0  = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
            assign hi1  = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + {{H{1'b0}}, 1'b1};
            assign sum  = {lo[L] ? hi1[H-1:0] : hi0[H-1:0], lo[L-1:0]};
            assign cout = lo[L] ? hi1[H] : hi0[H];
        end
    endgenerate
endmodule

module multiword_add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input logic                      clk,
    input logic                      rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state;
    logic [IW-1:0]               idx;
    logic [WORDS-1:0][N-1:0]     a_q, b_q, sum_q;
    logic                        carry_q, cout_q, ovf_q;
    logic                        start_ready_q, res_valid_q, busy_q;
    logic [N-1:0]                s_w;
    logic                        c_w;
    logic                        last_w;

    carry_select_adder #(.N(N)) u_csa (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .sum  (s_w),
        .cout (c_w)
    );

    assign last_w = (idx == IW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid && start_ready_q) begin
                        a_q           <= bus.a;
                        // Subtraction is a + ~b + 1: invert here, the +1 enters as word-0 carry.
                        b_q           <= bus.op_sub ? ~bus.b : bus.b;
                        carry_q       <= bus.op_sub;
                        idx           <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= s_w;
                    carry_q    <= c_w;
                    if (last_w) begin
                        idx         <= '0;
                        cout_q      <= c_w;
                        ovf_q       <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                                       (s_w[N-1] != a_q[WORDS-1][N-1]);
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;
    assign bus.busy        = busy_q;
endmodule
